// File: rtl/mc6502_interrupt_sequencer.sv
// 6502-style interrupt/reset entry sequencer: pushes PC and PSR, fetches the vector
// and loads the PC. Also performs the reset vector fetch after rst_x is released.
module mc6502_interrupt_sequencer (
   input  logic        clk,
   input  logic        rst_x,
   input  logic        i_nmi_x,
   input  logic        i_irq_x,
   input  logic        i_brk,
   input  logic        i_boundary,
   input  logic [7:0]  i_psr,
   input  logic [15:0] i_pc,
   input  logic [7:0]  i_sp,
   input  logic [7:0]  i_data,
   output logic [15:0] o_addr,
   output logic [7:0]  o_data,
   output logic        o_we,
   output logic        o_re,
   output logic        o_sp_dec,
   output logic        o_set_i,
   output logic        o_i,
   output logic        o_set_b,
   output logic        o_b,
   output logic        o_set_pc,
   output logic [15:0] o_pc,
   output logic        o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_PCH,
      S_PUSH_PCL,
      S_PUSH_PSR,
      S_VEC_L,
      S_VEC_H
   } state_t;

   typedef enum logic [1:0] {
      K_RESET,
      K_NMI,
      K_IRQ,
      K_BRK
   } kind_t;

   state_t      state, state_nx;
   kind_t       kind, kind_nx;
   logic        nmi_q;
   logic        nmi_pend;
   logic        nmi_edge;
   logic        nmi_clr;
   logic        accept;
   logic        pushing;
   logic [7:0]  sp_q;
   logic [15:0] pc_q;
   logic [7:0]  lo_q;
   logic [15:0] vec;
   logic [7:0]  psr_push;

   function automatic logic [15:0] vector_of(input kind_t k);
      case (k)
         K_NMI:   vector_of = 16'hFFFA;
         K_RESET: vector_of = 16'hFFFC;
         default: vector_of = 16'hFFFE;
      endcase
   endfunction

   assign nmi_edge = nmi_q & ~i_nmi_x;
   assign nmi_clr  = accept && (kind_nx == K_NMI);
   assign pushing  = (state == S_PUSH_PCH) || (state == S_PUSH_PCL) || (state == S_PUSH_PSR);
   assign vec      = vector_of(kind);

   // Pushed status byte carries the B flag in bit 4 in place of the live bit.
   always_comb begin
      psr_push    = i_psr;
      psr_push[4] = (kind == K_BRK);
   end

   always_comb begin
      state_nx = state;
      kind_nx  = kind;
      accept   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_boundary) begin
               if (nmi_pend) begin
                  kind_nx = K_NMI;
                  accept  = 1'b1;
               end else if (!i_irq_x && !i_psr[2]) begin
                  kind_nx = K_IRQ;
                  accept  = 1'b1;
               end else if (i_brk) begin
                  kind_nx = K_BRK;
                  accept  = 1'b1;
               end
            end
            if (accept) state_nx = S_PUSH_PCH;
         end
         S_PUSH_PCH: state_nx = S_PUSH_PCL;
         S_PUSH_PCL: state_nx = S_PUSH_PSR;
         S_PUSH_PSR: state_nx = S_VEC_L;
         S_VEC_L:    state_nx = S_VEC_H;
         S_VEC_H:    state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state    <= S_VEC_L;
         kind     <= K_RESET;
         nmi_q    <= 1'b1;
         nmi_pend <= 1'b0;
         sp_q     <= 8'h00;
         pc_q     <= 16'h0000;
         lo_q     <= 8'h00;
      end else begin
         state <= state_nx;
         kind  <= kind_nx;
         nmi_q <= i_nmi_x;
         // A fresh edge wins over the clear so a back-to-back NMI is not lost.
         if (nmi_edge)
            nmi_pend <= 1'b1;
         else if (nmi_clr)
            nmi_pend <= 1'b0;
         if (accept) begin
            pc_q <= i_pc;
            sp_q <= i_sp;
         end else if (pushing) begin
            sp_q <= sp_q - 8'd1;
         end
         if (state == S_VEC_L) lo_q <= i_data;
      end
   end

   always_comb begin
      o_addr   = 16'h0000;
      o_data   = 8'h00;
      o_we     = 1'b0;
      o_re     = 1'b0;
      o_sp_dec = 1'b0;
      o_set_i  = 1'b0;
      o_i      = 1'b0;
      o_set_b  = 1'b0;
      o_b      = 1'b0;
      o_set_pc = 1'b0;
      o_pc     = 16'h0000;
      case (state)
         S_PUSH_PCH, S_PUSH_PCL, S_PUSH_PSR: begin
            o_we     = 1'b1;
            o_addr   = {8'h01, sp_q};
            o_sp_dec = 1'b1;
            if (state == S_PUSH_PCH)
               o_data = pc_q[15:8];
            else if (state == S_PUSH_PCL)
               o_data = pc_q[7:0];
            else begin
               o_data  = psr_push;
               o_set_b = 1'b1;
               o_b     = (kind == K_BRK);
            end
         end
         S_VEC_L: begin
            o_re    = 1'b1;
            o_addr  = vec;
            o_set_i = 1'b1;
            o_i     = 1'b1;
         end
         S_VEC_H: begin
            o_re     = 1'b1;
            o_addr   = vec + 16'd1;
            o_set_pc = 1'b1;
            o_pc     = {i_data, lo_q};
         end
         default: ;
      endcase
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// Bench for mc6502_interrupt_sequencer: table of entry scenarios plus hand-written
// NMI/reset corner sequences, checked against a bus-transaction scoreboard.
module tb_mc6502_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst_x;
   logic        i_nmi_x, i_irq_x, i_brk, i_boundary;
   logic [7:0]  i_psr, i_sp, i_data;
   logic [15:0] i_pc;
   logic [15:0] o_addr, o_pc;
   logic [7:0]  o_data;
   logic        o_we, o_re, o_sp_dec, o_set_i, o_i, o_set_b, o_b, o_set_pc, o_busy;

   always #5 clk = ~clk;

   mc6502_interrupt_sequencer dut (
      .clk(clk), .rst_x(rst_x), .i_nmi_x(i_nmi_x), .i_irq_x(i_irq_x), .i_brk(i_brk),
      .i_boundary(i_boundary), .i_psr(i_psr), .i_pc(i_pc), .i_sp(i_sp), .i_data(i_data),
      .o_addr(o_addr), .o_data(o_data), .o_we(o_we), .o_re(o_re), .o_sp_dec(o_sp_dec),
      .o_set_i(o_set_i), .o_i(o_i), .o_set_b(o_set_b), .o_b(o_b), .o_set_pc(o_set_pc),
      .o_pc(o_pc), .o_busy(o_busy)
   );

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } bus_t;

   typedef struct {
      logic        irq_x;
      logic        brk;
      logic [7:0]  psr;
      logic [15:0] pc;
      logic [7:0]  sp;
      logic        taken;
      logic [15:0] vec;
      logic        b;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0, spdec_cnt = 0, seti_cnt = 0, setb_cnt = 0, setpc_cnt = 0;
   bus_t exp_bus_q[$];
   logic [15:0] exp_pc_q[$];
   logic exp_b_q[$];
   bus_t mon_e;

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      case (a)
         16'hFFFA: mem_rd = 8'h5A;
         16'hFFFB: mem_rd = 8'hA5;
         16'hFFFC: mem_rd = 8'h34;
         16'hFFFD: mem_rd = 8'h12;
         16'hFFFE: mem_rd = 8'hEF;
         16'hFFFF: mem_rd = 8'hBE;
         default:  mem_rd = 8'h00;
      endcase
   endfunction

   always_comb i_data = mem_rd(o_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [15:0] vec, input logic [15:0] pc,
                           input logic [7:0] sp, input logic [7:0] psr, input logic b);
      logic [7:0] s1, s2, pp;
      s1 = sp - 8'd1;
      s2 = sp - 8'd2;
      pp = {psr[7:5], b, psr[3:0]};
      exp_bus_q.push_back(bus_t'{1'b1, {8'h01, sp}, pc[15:8]});
      exp_bus_q.push_back(bus_t'{1'b1, {8'h01, s1}, pc[7:0]});
      exp_bus_q.push_back(bus_t'{1'b1, {8'h01, s2}, pp});
      exp_bus_q.push_back(bus_t'{1'b0, vec, 8'h00});
      exp_bus_q.push_back(bus_t'{1'b0, vec + 16'd1, 8'h00});
      exp_pc_q.push_back({mem_rd(vec + 16'd1), mem_rd(vec)});
      exp_b_q.push_back(b);
   endtask

   task automatic push_reset_fetch();
      exp_bus_q.push_back(bus_t'{1'b0, 16'hFFFC, 8'h00});
      exp_bus_q.push_back(bus_t'{1'b0, 16'hFFFD, 8'h00});
      exp_pc_q.push_back(16'h1234);
   endtask

   task automatic clear_counts();
      busy_cnt = 0; spdec_cnt = 0; seti_cnt = 0; setb_cnt = 0; setpc_cnt = 0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (o_busy && n < 20) begin
         step();
         n++;
      end
      check("idle_timeout", o_busy, 0);
   endtask

   task automatic end_seq(input string tag, input int e_busy, input int e_spdec,
                          input int e_seti, input int e_setb, input int e_setpc);
      check({tag, "_busy_cycles"}, busy_cnt, e_busy);
      check({tag, "_sp_dec"}, spdec_cnt, e_spdec);
      check({tag, "_set_i"}, seti_cnt, e_seti);
      check({tag, "_set_b"}, setb_cnt, e_setb);
      check({tag, "_set_pc"}, setpc_cnt, e_setpc);
      check({tag, "_bus_left"}, exp_bus_q.size(), 0);
      check({tag, "_pc_left"}, exp_pc_q.size(), 0);
      exp_bus_q.delete();
      exp_pc_q.delete();
      exp_b_q.delete();
      clear_counts();
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on each bus cycle.
   always @(negedge clk) begin
      if (rst_x) begin
         if (o_busy) busy_cnt++;
         if (o_sp_dec) spdec_cnt++;
         if (!o_busy)
            check("idle_quiet", {o_we, o_re, o_sp_dec, o_set_i, o_set_b, o_set_pc, o_addr, o_data}, 0);
         if (o_set_i) begin
            seti_cnt++;
            check("o_i", o_i, 1);
         end
         if (o_set_b) begin
            setb_cnt++;
            if (exp_b_q.size() == 0) check("set_b_unexpected", 1, 0);
            else check("o_b", o_b, exp_b_q.pop_front());
         end
         if (o_we || o_re) begin
            if (exp_bus_q.size() == 0) begin
               check("bus_unexpected", {o_we, o_re, o_addr}, 0);
            end else begin
               mon_e = exp_bus_q.pop_front();
               check("bus_we", o_we, mon_e.we);
               check("bus_re", o_re, !mon_e.we);
               check("bus_addr", o_addr, mon_e.addr);
               if (mon_e.we) check("bus_data", o_data, mon_e.data);
            end
         end
         if (o_set_pc) begin
            setpc_cnt++;
            if (exp_pc_q.size() == 0) check("set_pc_unexpected", 1, 0);
            else check("o_pc", o_pc, exp_pc_q.pop_front());
         end
      end
   end

   vec_t tbl [6];

   initial begin
      tbl[0] = '{1'b0, 1'b0, 8'h20, 16'hC123, 8'hFD, 1'b1, 16'hFFFE, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 8'h24, 16'h2222, 8'hFD, 1'b0, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'h20, 16'h3456, 8'hC0, 1'b1, 16'hFFFE, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 8'hE3, 16'h1000, 8'h01, 1'b1, 16'hFFFE, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 8'h20, 16'h7777, 8'h80, 1'b0, 16'h0000, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 8'h04, 16'hABCD, 8'h02, 1'b1, 16'hFFFE, 1'b1};

      rst_x = 1'b0; i_nmi_x = 1'b1; i_irq_x = 1'b1; i_brk = 1'b0; i_boundary = 1'b0;
      i_psr = 8'h20; i_pc = 16'h0000; i_sp = 8'hFF;

      // Reset: state parked on the reset vector fetch.
      step();
      step();
      check("rst_busy", o_busy, 1);
      check("rst_re", o_re, 1);
      check("rst_addr", o_addr, 16'hFFFC);
      check("rst_we", o_we, 0);
      check("rst_sp_dec", o_sp_dec, 0);
      push_reset_fetch();
      rst_x = 1'b1;
      wait_idle();
      end_seq("reset", 2, 0, 1, 0, 1);

      for (int k = 0; k < 6; k++) begin
         i_irq_x = tbl[k].irq_x; i_brk = tbl[k].brk; i_psr = tbl[k].psr;
         i_pc = tbl[k].pc; i_sp = tbl[k].sp; i_boundary = 1'b1;
         if (tbl[k].taken) push_seq(tbl[k].vec, tbl[k].pc, tbl[k].sp, tbl[k].psr, tbl[k].b);
         step();
         if (tbl[k].taken) begin
            i_boundary = 1'b0; i_irq_x = 1'b1; i_brk = 1'b0;
            wait_idle();
            end_seq("vec", 5, 3, 1, 1, 1);
         end else begin
            repeat (3) step();
            i_boundary = 1'b0; i_irq_x = 1'b1; i_brk = 1'b0;
            step();
            end_seq("vec_idle", 0, 0, 0, 0, 0);
         end
      end

      // NMI edge during an IRQ sequence is held and taken at the next boundary.
      i_irq_x = 1'b0; i_psr = 8'h20; i_pc = 16'h4000; i_sp = 8'hF0; i_boundary = 1'b1;
      push_seq(16'hFFFE, 16'h4000, 8'hF0, 8'h20, 1'b0);
      step();
      i_boundary = 1'b0; i_irq_x = 1'b1; i_nmi_x = 1'b0;
      wait_idle();
      step();
      end_seq("irq_then_nmi", 5, 3, 1, 1, 1);
      i_pc = 16'h4010; i_sp = 8'hED; i_boundary = 1'b1;
      push_seq(16'hFFFA, 16'h4010, 8'hED, 8'h20, 1'b0);
      step();
      i_boundary = 1'b0;
      wait_idle();
      end_seq("nmi", 5, 3, 1, 1, 1);
      i_boundary = 1'b1;
      repeat (3) step();
      i_boundary = 1'b0;
      i_nmi_x = 1'b1;
      step();
      end_seq("nmi_once", 0, 0, 0, 0, 0);

      // New NMI edge in the same cycle the pending one is accepted.
      i_nmi_x = 1'b0;
      step();
      i_nmi_x = 1'b1;
      step();
      i_nmi_x = 1'b0; i_pc = 16'h5000; i_sp = 8'h80; i_psr = 8'h21; i_boundary = 1'b1;
      push_seq(16'hFFFA, 16'h5000, 8'h80, 8'h21, 1'b0);
      step();
      i_boundary = 1'b0;
      wait_idle();
      end_seq("nmi_coincide", 5, 3, 1, 1, 1);
      i_pc = 16'h5005; i_sp = 8'h7D; i_boundary = 1'b1;
      push_seq(16'hFFFA, 16'h5005, 8'h7D, 8'h21, 1'b0);
      step();
      i_boundary = 1'b0; i_nmi_x = 1'b1;
      wait_idle();
      end_seq("nmi_second", 5, 3, 1, 1, 1);

      // Reset asserted in the middle of an IRQ sequence.
      i_irq_x = 1'b0; i_psr = 8'h20; i_pc = 16'h6000; i_sp = 8'h40; i_boundary = 1'b1;
      exp_bus_q.push_back(bus_t'{1'b1, 16'h0140, 8'h60});
      step();
      i_boundary = 1'b0; i_irq_x = 1'b1;
      step();
      rst_x = 1'b0;
      #1;
      clear_counts();
      check("rst_mid_busy", o_busy, 1);
      check("rst_mid_addr", o_addr, 16'hFFFC);
      check("rst_mid_we", o_we, 0);
      check("rst_mid_bus_left", exp_bus_q.size(), 0);
      exp_bus_q.delete();
      step();
      push_reset_fetch();
      rst_x = 1'b1;
      wait_idle();
      end_seq("rst_mid", 2, 0, 1, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
